// File: rtl/encoder_8to3_rr_pkg.sv
// Shared constants, types and helpers for the round-robin 8-to-3 encoder.
package encoder_pkg;

    localparam int unsigned N    = 8;
    localparam int unsigned IDXW = $clog2(N);

    typedef logic [IDXW-1:0] idx_t;
    typedef logic [N-1:0]    req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One-hot decode of an index; the grant vector is always derived from this.
    function automatic req_t idx_to_onehot(input idx_t idx);
        req_t r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/encoder_8to3_rr_rr_priority_find.sv
// Rotating-priority search: first set request at or after ptr, wrapping at N.
module rr_priority_find
    import encoder_pkg::*;
(
    input  logic [N-1:0]    request,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0] rot;
    idx_t         off;
    logic         hit;

    // Rotate so ptr lands at bit 0, find the lowest set bit, then un-rotate.
    always_comb begin
        rot   = '0;
        off   = '0;
        hit   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            rot[i] = request[idx_t'(i) + ptr];
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !hit) begin
                off = idx_t'(i);
                hit = 1'b1;
            end
        end
        found = |request;
        idx   = off + ptr;
    end

endmodule

// File: rtl/encoder_8to3_rr.sv
// Round-robin 8-to-3 encoder with registered index/grant and valid/ready handshake.
module encoder_8to3_rr
    import encoder_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N-1:0]    request,
    input  logic            ready,
    output logic            valid,
    output logic [IDXW-1:0] encoded,
    output logic [N-1:0]    grant
);

    state_t state_q, state_d;
    idx_t   ptr_q, ptr_d;
    idx_t   encoded_q, encoded_d;
    req_t   grant_q, grant_d;

    logic   pick_found;
    idx_t   pick_idx;
    logic   load;

    rr_priority_find u_find (
        .request (request),
        .ptr     (ptr_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Next-state: load when the slot is empty or being drained this edge.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        encoded_d = encoded_q;
        grant_d   = grant_q;
        load      = enable && pick_found && ((state_q == EMPTY) || ready);
        if (load) begin
            state_d   = FULL;
            encoded_d = pick_idx;
            grant_d   = idx_to_onehot(pick_idx);
            ptr_d     = pick_idx + idx_t'(1);
        end else if ((state_q == FULL) && ready) begin
            state_d = EMPTY;
            grant_d = '0;
        end
    end

    // State, pointer and output registers; async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            ptr_q     <= '0;
            encoded_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            encoded_q <= encoded_d;
            grant_q   <= grant_d;
        end
    end

    assign valid   = (state_q == FULL);
    assign encoded = encoded_q;
    assign grant   = grant_q;

endmodule
